// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared states, opcodes and ALU codes for the multicycle controller (TRAP state under CTRL_ILLEGAL_TRAP_EN)
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        JAL,
        BEQ
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        TRAP
`endif
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [4:0] ALUC_ADD = 5'b00000;
    localparam logic [4:0] ALUC_SUB = 5'b00001;
    localparam logic [4:0] ALUC_AND = 5'b00010;
    localparam logic [4:0] ALUC_OR  = 5'b00011;
    localparam logic [4:0] ALUC_SLT = 5'b00101;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational alu_op/funct decode to a 5-bit ALU operation code
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [4:0] alu_control
);

    always_comb begin
        alu_control = ALUC_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALUC_ADD;
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // only R-type sub sets both bits; addi must stay an add
                    3'b000:  alu_control = (op5 & funct7b5) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  alu_control = ALUC_SLT;
                    3'b110:  alu_control = ALUC_OR;
                    3'b111:  alu_control = ALUC_AND;
                    default: alu_control = ALUC_ADD;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/controller_multicycle.sv
// rtl/controller_multicycle.sv - Moore multicycle RISC-V controller; CTRL_ILLEGAL_TRAP_EN adds a sticky illegal-opcode trap
module controller_multicycle
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           imm_src,
    output logic [ALUCTRL_W-1:0] alu_control
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                 illegal
`endif
);

    state_e     state_q, state_d;
    logic       pc_update, branch, ir_en, rw_en, mw_en;
    logic [1:0] alu_op;
    logic [4:0] alu_ctl;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:      state_d = TRAP;
`else
                    default:      state_d = FETCH;
`endif
                endcase
            end
            MEMADR:                 state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:                state_d = MEMWB;
            EXECR, EXECI, JAL:      state_d = ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP:                   state_d = TRAP;
`endif
            default:                state_d = FETCH;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == TRAP) illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end
`endif

    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_en      = 1'b0;
        rw_en      = 1'b0;
        mw_en      = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = ALUOP_ADD;
        case (state_q)
            FETCH:    begin ir_en = 1'b1; alu_src_b = 2'b10; result_src = 2'b10; pc_update = 1'b1; end
            DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
            MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
            MEMREAD:  adr_src = 1'b1;
            MEMWB:    begin result_src = 2'b01; rw_en = 1'b1; end
            MEMWRITE: begin adr_src = 1'b1; mw_en = 1'b1; end
            EXECR:    begin alu_src_a = 2'b10; alu_op = ALUOP_FUNCT; end
            EXECI:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = ALUOP_FUNCT; end
            ALUWB:    rw_en = 1'b1;
            JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_update = 1'b1; end
            BEQ:      begin alu_src_a = 2'b10; branch = 1'b1; alu_op = ALUOP_SUB; end
            default:  ;
        endcase
    end

    // State is held at FETCH during reset, so only the write strobes need explicit gating
    assign pc_write  = reset_n & (pc_update | (branch & zero));
    assign ir_write  = reset_n & ir_en;
    assign reg_write = reset_n & rw_en;
    assign mem_write = reset_n & mw_en;

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_ctl)
    );

    assign alu_control = ALUCTRL_W'(alu_ctl);

endmodule

// File: tb/tb_controller_multicycle.sv
// tb/tb_controller_multicycle.sv - table-driven bench for controller_multicycle (trap checks under CTRL_ILLEGAL_TRAP_EN)
module tb_controller_multicycle;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [5:0] alu_control;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    always #5 clk = ~clk;

    controller_multicycle #(.ALUCTRL_W(6)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal     (illegal)
`endif
    );

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, imm_src, alu_control}
    logic [18:0] act;
    assign act = {pc_write, adr_src, mem_write, ir_write, reg_write,
                  result_src, alu_src_a, alu_src_b, imm_src, alu_control};

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [18:0] e(input logic pw, input logic as_, input logic mw, input logic iw,
                                      input logic rw, input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] is, input logic [5:0] ac);
        return {pw, as_, mw, iw, rw, rs, sa, sb, is, ac};
    endfunction

    task automatic add(input string n, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic [18:0] x);
        vec_t v;
        v.name = n; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = x;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [18:0] x);
        n_cmp++;
        if (act !== x) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, x);
        end
    endtask

    task automatic step(input string name, input logic [18:0] x);
        @(negedge clk);
        check(name, x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; op = LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;

        // lw: 5 cycles
        add("lw_F",   LW, 3'b010, 0, 0, e(1,0,0,1,0, 2'd2,2'd0,2'd2, 2'd0, 6'd0));
        add("lw_D",   LW, 3'b010, 0, 0, e(0,0,0,0,0, 2'd0,2'd1,2'd1, 2'd0, 6'd0));
        add("lw_MA",  LW, 3'b010, 0, 0, e(0,0,0,0,0, 2'd0,2'd2,2'd1, 2'd0, 6'd0));
        add("lw_MR",  LW, 3'b010, 0, 0, e(0,1,0,0,0, 2'd0,2'd0,2'd0, 2'd0, 6'd0));
        add("lw_WB",  LW, 3'b010, 0, 0, e(0,0,0,0,1, 2'd1,2'd0,2'd0, 2'd0, 6'd0));
        // sub R-type with zero high outside BEQ
        add("sub_F",  RT, 3'b000, 1, 1, e(1,0,0,1,0, 2'd2,2'd0,2'd2, 2'd0, 6'd0));
        add("sub_D",  RT, 3'b000, 1, 1, e(0,0,0,0,0, 2'd0,2'd1,2'd1, 2'd0, 6'd0));
        add("sub_EX", RT, 3'b000, 1, 1, e(0,0,0,0,0, 2'd0,2'd2,2'd0, 2'd0, 6'd1));
        add("sub_WB", RT, 3'b000, 1, 1, e(0,0,0,0,1, 2'd0,2'd0,2'd0, 2'd0, 6'd0));
        // beq taken / not taken
        add("beq1_F", BQ, 3'b000, 0, 1, e(1,0,0,1,0, 2'd2,2'd0,2'd2, 2'd2, 6'd0));
        add("beq1_D", BQ, 3'b000, 0, 1, e(0,0,0,0,0, 2'd0,2'd1,2'd1, 2'd2, 6'd0));
        add("beq1_B", BQ, 3'b000, 0, 1, e(1,0,0,0,0, 2'd0,2'd2,2'd0, 2'd2, 6'd1));
        add("beq0_F", BQ, 3'b000, 0, 0, e(1,0,0,1,0, 2'd2,2'd0,2'd2, 2'd2, 6'd0));
        add("beq0_D", BQ, 3'b000, 0, 0, e(0,0,0,0,0, 2'd0,2'd1,2'd1, 2'd2, 6'd0));
        add("beq0_B", BQ, 3'b000, 0, 0, e(0,0,0,0,0, 2'd0,2'd2,2'd0, 2'd2, 6'd1));
`ifndef CTRL_ILLEGAL_TRAP_EN
        // illegal opcode falls back to FETCH with no strobes
        add("bad_F",  BAD, 3'b000, 0, 1, e(1,0,0,1,0, 2'd2,2'd0,2'd2, 2'd0, 6'd0));
        add("bad_D",  BAD, 3'b000, 0, 1, e(0,0,0,0,0, 2'd0,2'd1,2'd1, 2'd0, 6'd0));
`endif
        // sw: 4 cycles, single mem_write
        add("sw_F",   SW, 3'b010, 0, 0, e(1,0,0,1,0, 2'd2,2'd0,2'd2, 2'd1, 6'd0));
        add("sw_D",   SW, 3'b010, 0, 0, e(0,0,0,0,0, 2'd0,2'd1,2'd1, 2'd1, 6'd0));
        add("sw_MA",  SW, 3'b010, 0, 0, e(0,0,0,0,0, 2'd0,2'd2,2'd1, 2'd1, 6'd0));
        add("sw_MW",  SW, 3'b010, 0, 0, e(0,1,1,0,0, 2'd0,2'd0,2'd0, 2'd1, 6'd0));
        // ori
        add("ori_F",  IT, 3'b110, 0, 0, e(1,0,0,1,0, 2'd2,2'd0,2'd2, 2'd0, 6'd0));
        add("ori_D",  IT, 3'b110, 0, 0, e(0,0,0,0,0, 2'd0,2'd1,2'd1, 2'd0, 6'd0));
        add("ori_EX", IT, 3'b110, 0, 0, e(0,0,0,0,0, 2'd0,2'd2,2'd1, 2'd0, 6'd3));
        add("ori_WB", IT, 3'b110, 0, 0, e(0,0,0,0,1, 2'd0,2'd0,2'd0, 2'd0, 6'd0));
        // addi with funct7b5 set must stay add (op[5]=0)
        add("adi_F",  IT, 3'b000, 1, 0, e(1,0,0,1,0, 2'd2,2'd0,2'd2, 2'd0, 6'd0));
        add("adi_D",  IT, 3'b000, 1, 0, e(0,0,0,0,0, 2'd0,2'd1,2'd1, 2'd0, 6'd0));
        add("adi_EX", IT, 3'b000, 1, 0, e(0,0,0,0,0, 2'd0,2'd2,2'd1, 2'd0, 6'd0));
        add("adi_WB", IT, 3'b000, 1, 0, e(0,0,0,0,1, 2'd0,2'd0,2'd0, 2'd0, 6'd0));
        // jal
        add("jal_F",  JL, 3'b000, 0, 0, e(1,0,0,1,0, 2'd2,2'd0,2'd2, 2'd3, 6'd0));
        add("jal_D",  JL, 3'b000, 0, 0, e(0,0,0,0,0, 2'd0,2'd1,2'd1, 2'd3, 6'd0));
        add("jal_J",  JL, 3'b000, 0, 0, e(1,0,0,0,0, 2'd0,2'd1,2'd2, 2'd3, 6'd0));
        add("jal_WB", JL, 3'b000, 0, 0, e(0,0,0,0,1, 2'd0,2'd0,2'd0, 2'd3, 6'd0));
        // and / slt / add R-types
        add("and_F",  RT, 3'b111, 0, 0, e(1,0,0,1,0, 2'd2,2'd0,2'd2, 2'd0, 6'd0));
        add("and_D",  RT, 3'b111, 0, 0, e(0,0,0,0,0, 2'd0,2'd1,2'd1, 2'd0, 6'd0));
        add("and_EX", RT, 3'b111, 0, 0, e(0,0,0,0,0, 2'd0,2'd2,2'd0, 2'd0, 6'd2));
        add("and_WB", RT, 3'b111, 0, 0, e(0,0,0,0,1, 2'd0,2'd0,2'd0, 2'd0, 6'd0));
        add("slt_F",  RT, 3'b010, 0, 0, e(1,0,0,1,0, 2'd2,2'd0,2'd2, 2'd0, 6'd0));
        add("slt_D",  RT, 3'b010, 0, 0, e(0,0,0,0,0, 2'd0,2'd1,2'd1, 2'd0, 6'd0));
        add("slt_EX", RT, 3'b010, 0, 0, e(0,0,0,0,0, 2'd0,2'd2,2'd0, 2'd0, 6'd5));
        add("slt_WB", RT, 3'b010, 0, 0, e(0,0,0,0,1, 2'd0,2'd0,2'd0, 2'd0, 6'd0));
        add("add_F",  RT, 3'b000, 0, 0, e(1,0,0,1,0, 2'd2,2'd0,2'd2, 2'd0, 6'd0));
        add("add_D",  RT, 3'b000, 0, 0, e(0,0,0,0,0, 2'd0,2'd1,2'd1, 2'd0, 6'd0));
        add("add_EX", RT, 3'b000, 0, 0, e(0,0,0,0,0, 2'd0,2'd2,2'd0, 2'd0, 6'd0));
        add("add_WB", RT, 3'b000, 0, 0, e(0,0,0,0,1, 2'd0,2'd0,2'd0, 2'd0, 6'd0));

        // held in reset: strobes low, selects at FETCH values
        #3;
        check("reset", e(0,0,0,0,0, 2'd2,2'd0,2'd2, 2'd0, 6'd0));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            op = tbl[i].op; funct3 = tbl[i].f3; funct7b5 = tbl[i].f7; zero = tbl[i].z;
            step(tbl[i].name, tbl[i].exp);
        end

        // reset pulsed during MEMREAD abandons the load
        op = LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        step("rlw_F",  e(1,0,0,1,0, 2'd2,2'd0,2'd2, 2'd0, 6'd0));
        step("rlw_D",  e(0,0,0,0,0, 2'd0,2'd1,2'd1, 2'd0, 6'd0));
        step("rlw_MA", e(0,0,0,0,0, 2'd0,2'd2,2'd1, 2'd0, 6'd0));
        @(negedge clk);
        check("rlw_MR", e(0,1,0,0,0, 2'd0,2'd0,2'd0, 2'd0, 6'd0));
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid", e(0,0,0,0,0, 2'd2,2'd0,2'd2, 2'd0, 6'd0));
        @(posedge clk);
        #1;
        check("rst_hold", e(0,0,0,0,0, 2'd2,2'd0,2'd2, 2'd0, 6'd0));
        reset_n = 1'b1;
        step("post_F",  e(1,0,0,1,0, 2'd2,2'd0,2'd2, 2'd0, 6'd0));
        step("post_D",  e(0,0,0,0,0, 2'd0,2'd1,2'd1, 2'd0, 6'd0));
        step("post_MA", e(0,0,0,0,0, 2'd0,2'd2,2'd1, 2'd0, 6'd0));
        step("post_MR", e(0,1,0,0,0, 2'd0,2'd0,2'd0, 2'd0, 6'd0));
        step("post_WB", e(0,0,0,0,1, 2'd1,2'd0,2'd0, 2'd0, 6'd0));

`ifdef CTRL_ILLEGAL_TRAP_EN
        n_cmp++;
        if (illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_init: got %b want 0", illegal);
        end
        op = BAD;
        step("trap_F", e(1,0,0,1,0, 2'd2,2'd0,2'd2, 2'd0, 6'd0));
        step("trap_D", e(0,0,0,0,0, 2'd0,2'd1,2'd1, 2'd0, 6'd0));
        for (int c = 0; c < 20; c++) begin
            if (c == 10) op = LW;
            @(negedge clk);
            n_cmp++;
            if ({pc_write, mem_write, ir_write, reg_write, illegal} !== 5'b00001) begin
                n_bad++;
                $display("FAIL trap_hold[%0d]: got %b want 00001", c,
                         {pc_write, mem_write, ir_write, reg_write, illegal});
            end
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_clr: got %b want 0", illegal);
        end
        reset_n = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
